dac_spi_multi: RTL and testbench
================================

# dac_spi_multi

Parametrised multi-channel SPI transmitter for the DAC, successor to the single-word DAC SPI output block. One `send` pulse latches a word per channel and emits them as consecutive chip-select frames, channel 0 first, MSB first, with a programmable SCK divider and inter-frame gap. A one-deep pending buffer accepts a new `send` during a sequence so the audio-rate update path never drops a sample set.

## Interface
- `WORD_BITS`, 24: bits per frame (command + data), ≥2
- `CHANNELS`, 2: frames per sequence, ≥1
- `CLK_DIV`, 2: `clock_in` cycles per SCK half-period, ≥1
- `CS_GAP`, 2: `clock_in` cycles CS held high between frames, ≥1

- `clock_in`  in  1  system clock (133 MHz OSCH)
- `reset`  in  1  asynchronous, active-high reset
- `data_in`  in  CHANNELS*WORD_BITS  channel k word at bits [k*WORD_BITS +: WORD_BITS]
- `send`  in  1  request; sampled on rising `clock_in`
- `busy`  out  1  high while a sequence is in progress
- `done`  out  1  one-cycle pulse at end of each sequence
- `spi_cs_out`  out  1  active-low chip select
- `spi_clock_out`  out  1  SCK, idle low (mode 0)
- `spi_data_out`  out  1  MOSI, changes on SCK falling edge / frame start

## Operation
- Reset (async): `spi_cs_out`=1, `spi_clock_out`=0, `spi_data_out`=0, `busy`=0, `done`=0, pending cleared, state IDLE.
- States: IDLE → SETUP → SHIFT_LO ↔ SHIFT_HI → HOLD → GAP → (SETUP next channel | SETUP new sequence | IDLE).
- IDLE: `send`=1 latches `data_in` into shift store, channel counter=0, → SETUP.
- SETUP: CS low, SCK low, MSB of current channel on MOSI; CLK_DIV cycles, → SHIFT_HI.
- SHIFT_HI: SCK high CLK_DIV cycles. If bit counter = last bit → HOLD, else → SHIFT_LO.
- SHIFT_LO: SCK low, next bit on MOSI, CLK_DIV cycles, → SHIFT_HI.
- HOLD: SCK low, CLK_DIV cycles (CS hold), then CS high, → GAP.
- GAP: CS high, MOSI 0, CS_GAP cycles. Then: more channels → SETUP with channel+1; last channel → `done` pulse, then pending ? reload from shadow, → SETUP : → IDLE.
- `send` while busy: latch `data_in` into shadow register, set pending. Further `send` before drain overwrites shadow (latest wins); pending stays set.
- `send` on the same cycle GAP ends the last channel: treated as busy-time send (goes to pending, starts immediately).
- Counters: divider `$clog2(CLK_DIV)` min 1 bit; bit counter `$clog2(WORD_BITS)`; channel counter `$clog2(CHANNELS)` min 1 bit. No wrap beyond terminal values; counters reset to 0 on each state entry.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- `send` high at edge N (IDLE) → `spi_cs_out` low and `busy` high after edge N+1.
- First SCK rise CLK_DIV cycles after CS fall; bit period 2·CLK_DIV.
- CS low per frame: (2·WORD_BITS+1)·CLK_DIV cycles (98 for defaults).
- Sequence length: CHANNELS·((2·WORD_BITS+1)·CLK_DIV + CS_GAP) cycles (200 for defaults).
- `done` high exactly one cycle, the cycle after the final GAP cycle; `busy` drops with it unless pending, in which case `busy` stays high and CS falls that same cycle.
- Reset mid-frame: outputs return to reset values immediately (CS deasserts asynchronously); pending discarded.

## Structure
- Package `dac_spi_pkg`: state enum `dac_spi_state_t`, helper function `cnt_w(n)` = max(1,$clog2(n)).
- Sub-module `spi_frame_tx`: single-frame shifter (SETUP/SHIFT/HOLD, divider, bit counter, `start`/`frame_done`); top holds channel sequencing, GAP, shadow/pending, `busy`/`done`.
- Parameter legality checked with elaboration-time assertion.

## Test plan
- Reset: hold `reset` 20 ns → CS=1, SCK=0, MOSI=0, busy=0, done=0; assert reset mid-frame → CS high same cycle.
- Single sequence, defaults, ch0=0x31AACC, ch1=0xB155CD → two 98-cycle CS frames, 2-cycle gap, SPI monitor decodes 0x31AACC then 0xB155CD, `done` one cycle at cycle 201.
- CLK_DIV=1, CHANNELS=1, WORD_BITS=16, 0xA5F0 → 33-cycle frame, SCK period 2 cycles, decoded 0xA5F0.
- Pending: `send` 0x111111/0x222222, then during ch0 `send` 0x333333/0x444444 → four frames back-to-back, `busy` continuous, two `done` pulses.
- Overwrite: two busy-time sends (0x555555…, then 0x666666…) → only 0x666666 set transmitted after first sequence.
- Boundary: `send` on the final GAP cycle → new sequence starts on the `done` cycle, no IDLE cycle, CS gap still CS_GAP.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the multi-channel DAC SPI transmitter.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StGap
  } dac_spi_state_t;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Single-frame SPI shifter: CS low, MSB-first bits on mode-0 SCK, then a CS hold phase.
module spi_frame_tx
  import dac_spi_pkg::*;
#(
  parameter int WORD_BITS = 24,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] word,
  output logic                 frame_done,
  output logic                 spi_cs_out,
  output logic                 spi_clock_out,
  output logic                 spi_data_out
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BitLast = BW'(WORD_BITS - 1);

  dac_spi_state_t state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           cs_q, cs_d;
  logic           sck_q, sck_d;
  logic           mosi_q, mosi_d;
  logic           div_end;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
    div_end    = (div_q == DivLast);
    if (state_q != StIdle && !div_end) begin
      div_d = div_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (div_end) begin
          state_d = StShiftHi;
          div_d   = '0;
        end
      end
      StShiftHi: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BitLast) begin
            state_d = StHold;
          end else begin
            state_d = StShiftLo;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StShiftLo: begin
        if (div_end) begin
          state_d = StShiftHi;
          div_d   = '0;
        end
      end
      StHold: begin
        if (div_end) begin
          state_d    = StIdle;
          div_d      = '0;
          frame_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pins are a registered decode of the current state, one cycle behind it.
    cs_d   = (state_q == StIdle);
    sck_d  = (state_q == StShiftHi);
    mosi_d = (state_q == StIdle) ? 1'b0 : word[BitLast - bit_q];
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign spi_cs_out    = cs_q;
  assign spi_clock_out = sck_q;
  assign spi_data_out  = mosi_q;

endmodule

// File: rtl/dac_spi_multi.sv
// Multi-channel DAC SPI sequencer: channel stepping, inter-frame gap, one-deep pending set.
module dac_spi_multi
  import dac_spi_pkg::*;
#(
  parameter int WORD_BITS = 24,
  parameter int CHANNELS  = 2,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic [CHANNELS*WORD_BITS-1:0] data_in,
  input  logic                          send,
  output logic                          busy,
  output logic                          done,
  output logic                          spi_cs_out,
  output logic                          spi_clock_out,
  output logic                          spi_data_out
);

  localparam int CW    = cnt_w(CHANNELS);
  localparam int GW    = cnt_w(CS_GAP);
  localparam int DataW = CHANNELS * WORD_BITS;
  localparam logic [CW-1:0] ChLast  = CW'(CHANNELS - 1);
  localparam logic [GW-1:0] GapLast = GW'(CS_GAP - 1);

  if (WORD_BITS < 2 || CHANNELS < 1 || CLK_DIV < 1 || CS_GAP < 1) begin : gen_param_check
    $error("dac_spi_multi: illegal parameter set");
  end

  dac_spi_state_t       state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [DataW-1:0]     store_q, store_d;
  logic [DataW-1:0]     shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 seq_end_q, seq_end_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 start, frame_done, gap_end, last_gap;
  logic [WORD_BITS-1:0] word;

  assign word = store_q[int'(ch_q) * WORD_BITS +: WORD_BITS];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gap_d     = gap_q;
    store_d   = store_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    seq_end_d = 1'b0;
    start     = 1'b0;
    gap_end   = (state_q == StGap) && (gap_q == GapLast);
    last_gap  = gap_end && (ch_q == ChLast);

    // A send on the closing gap cycle is consumed directly by the restart below.
    if (send && state_q != StIdle && !last_gap) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (send) begin
          store_d = data_in;
          ch_d    = '0;
          start   = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (frame_done) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (!gap_end) begin
          gap_d = gap_q + 1'b1;
        end else if (ch_q != ChLast) begin
          ch_d    = ch_q + 1'b1;
          start   = 1'b1;
          state_d = StSetup;
        end else begin
          seq_end_d = 1'b1;
          if (send || pending_q) begin
            store_d   = send ? data_in : shadow_q;
            pending_d = 1'b0;
            ch_d      = '0;
            start     = 1'b1;
            state_d   = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Two stages so done lines up after the last registered gap cycle on the pins.
    done_d = seq_end_q;
    busy_d = (state_q != StIdle);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      gap_q     <= '0;
      store_q   <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seq_end_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gap_q     <= gap_d;
      store_q   <= store_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seq_end_q <= seq_end_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  spi_frame_tx #(
    .WORD_BITS(WORD_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_frame (
    .clock_in     (clock_in),
    .reset        (reset),
    .start        (start),
    .word         (word),
    .frame_done   (frame_done),
    .spi_cs_out   (spi_cs_out),
    .spi_clock_out(spi_clock_out),
    .spi_data_out (spi_data_out)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi: two configurations checked every cycle against a waveform model.
module tb_dac_spi_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send0 = 1'b0, send1 = 1'b0;
  logic [47:0] d0 = '0;
  logic [15:0] d1 = '0;
  logic        busy0, done0, cs0, sck0, mosi0;
  logic        busy1, done1, cs1, sck1, mosi1;

  dac_spi_multi #(.WORD_BITS(24), .CHANNELS(2), .CLK_DIV(2), .CS_GAP(2)) u_dut0 (
    .clock_in(clk), .reset(rst), .data_in(d0), .send(send0), .busy(busy0), .done(done0),
    .spi_cs_out(cs0), .spi_clock_out(sck0), .spi_data_out(mosi0)
  );

  dac_spi_multi #(.WORD_BITS(16), .CHANNELS(1), .CLK_DIV(1), .CS_GAP(2)) u_dut1 (
    .clock_in(clk), .reset(rst), .data_in(d1), .send(send1), .busy(busy1), .done(done1),
    .spi_cs_out(cs1), .spi_clock_out(sck1), .spi_data_out(mosi1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int pw[2]  = '{24, 16};
  int pch[2] = '{2, 1};
  int pcd[2] = '{2, 1};
  int pg[2]  = '{2, 2};

  // Model: the current and previous sequence, each as (start cycle, words).
  bit          m_act[2], m_pact[2], m_pend[2];
  int          m_start[2], m_pstart[2], m_done[2];
  logic [47:0] m_cur[2], m_prev[2], m_shadow[2];

  // Pin-level SPI monitor.
  logic        mon_pcs[2], mon_psck[2];
  logic [47:0] mon_sh[2];
  int          mon_low[2], mon_high[2], mon_dones[2], mon_lastdone[2];
  logic [47:0] q_w0[$], q_w1[$];
  int          q_f0[$], q_f1[$], q_g0[$], q_fall0[$];

  function automatic int seq_len(int k);
    return pch[k] * ((2 * pw[k] + 1) * pcd[k] + pg[k]);
  endfunction

  // {cs, sck, mosi} expected at offset pos of a sequence.
  function automatic logic [2:0] wave(int k, int pos, logic [47:0] words);
    int f, slot, ch, r, ph, b;
    f    = (2 * pw[k] + 1) * pcd[k];
    slot = f + pg[k];
    ch   = pos / slot;
    r    = pos % slot;
    if (r >= f) return 3'b100;
    ph = r / pcd[k];
    b  = ph / 2;
    if (b > pw[k] - 1) b = pw[k] - 1;
    return {1'b0, (ph % 2) == 1, words[ch * pw[k] + pw[k] - 1 - b]};
  endfunction

  task automatic check(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    q_w0.delete(); q_w1.delete(); q_f0.delete(); q_f1.delete();
    q_g0.delete(); q_fall0.delete();
    mon_dones[0] = 0; mon_dones[1] = 0;
  endtask

  task automatic do_cycle();
    logic [4:0]  act, exp;
    logic [2:0]  w;
    logic [47:0] d;
    logic        s, cs, sck, mosi;
    int          len, e;
    for (int k = 0; k < 2; k++) begin
      act = (k == 0) ? {cs0, sck0, mosi0, busy0, done0} : {cs1, sck1, mosi1, busy1, done1};
      len = seq_len(k);
      if (rst) begin
        exp = 5'b10000;
      end else begin
        if (m_act[k] && cyc >= m_start[k] && cyc < m_start[k] + len)
          exp = {wave(k, cyc - m_start[k], m_cur[k]), 2'b10};
        else if (m_pact[k] && cyc >= m_pstart[k] && cyc < m_pstart[k] + len)
          exp = {wave(k, cyc - m_pstart[k], m_prev[k]), 2'b10};
        else
          exp = 5'b10000;
        exp[0] = (cyc == m_done[k]);
      end
      check($sformatf("pins%0d@%0d", k, cyc), act, exp);

      cs = act[4]; sck = act[3]; mosi = act[2];
      if (rst) begin
        mon_pcs[k] = 1'b1; mon_psck[k] = 1'b0; mon_low[k] = 0; mon_high[k] = 0;
      end else begin
        if (!cs && mon_pcs[k]) begin
          if (k == 0) begin q_g0.push_back(mon_high[k]); q_fall0.push_back(cyc); end
          mon_low[k] = 0; mon_sh[k] = '0;
        end
        if (cs && !mon_pcs[k]) begin
          if (k == 0) begin q_w0.push_back(mon_sh[k]); q_f0.push_back(mon_low[k]); end
          else begin q_w1.push_back(mon_sh[k]); q_f1.push_back(mon_low[k]); end
          mon_high[k] = 0;
        end
        if (!cs) begin
          mon_low[k]++;
          if (sck && !mon_psck[k]) mon_sh[k] = {mon_sh[k][46:0], mosi};
        end else begin
          mon_high[k]++;
        end
        if (act[0]) begin mon_dones[k]++; mon_lastdone[k] = cyc; end
        mon_pcs[k] = cs; mon_psck[k] = sck;
      end

      // Decision taken by the edge that closes this cycle.
      e = cyc + 1;
      s = (k == 0) ? send0 : send1;
      d = (k == 0) ? d0 : {32'd0, d1};
      if (rst) begin
        m_act[k] = 0; m_pact[k] = 0; m_pend[k] = 0; m_done[k] = -1;
      end else if (!m_act[k] || e >= m_start[k] + len) begin
        if (s) begin
          m_pact[k] = m_act[k]; m_pstart[k] = m_start[k]; m_prev[k] = m_cur[k];
          m_act[k] = 1; m_start[k] = e + 1; m_cur[k] = d;
        end
      end else if (e == m_start[k] + len - 1) begin
        m_done[k] = e + 1;
        if (s || m_pend[k]) begin
          m_pact[k] = 1; m_pstart[k] = m_start[k]; m_prev[k] = m_cur[k];
          m_start[k] = e + 1; m_cur[k] = s ? d : m_shadow[k]; m_pend[k] = 0;
        end
      end else if (s) begin
        m_shadow[k] = d; m_pend[k] = 1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    do_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic fire0(logic [47:0] d);
    send0 = 1'b1; d0 = d;
    tick();
    send0 = 1'b0;
  endtask

  initial begin
    int se;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_pact[k] = 0; m_pend[k] = 0; m_done[k] = -1;
      m_start[k] = 0; m_pstart[k] = 0; m_cur[k] = '0; m_prev[k] = '0; m_shadow[k] = '0;
      mon_pcs[k] = 1; mon_psck[k] = 0; mon_sh[k] = '0; mon_low[k] = 0; mon_high[k] = 0;
      mon_dones[k] = 0; mon_lastdone[k] = -1;
    end

    // Reset held for 20 ns.
    ticks(2);
    check("reset_pins0", {cs0, sck0, mosi0, busy0, done0}, 5'b10000);
    check("reset_pins1", {cs1, sck1, mosi1, busy1, done1}, 5'b10000);
    rst = 1'b0;
    ticks(3);

    // Single sequence on both configurations.
    clear_mon();
    send0 = 1'b1; d0 = {24'hB155CD, 24'h31AACC};
    send1 = 1'b1; d1 = 16'hA5F0;
    se = cyc + 1;
    tick();
    send0 = 1'b0; send1 = 1'b0;
    ticks(210);
    check("single_nwords0", q_w0.size(), 2);
    if (q_w0.size() >= 2) begin
      check("single_word0", q_w0[0], 48'h31AACC);
      check("single_word1", q_w0[1], 48'hB155CD);
      check("single_frame0", q_f0[0], 98);
      check("single_frame1", q_f0[1], 98);
      check("single_gap", q_g0[1], 2);
    end
    check("single_done_at", mon_lastdone[0] - se, 201);
    check("single_ndone0", mon_dones[0], 1);
    check("cfg1_nwords", q_w1.size(), 1);
    if (q_w1.size() >= 1) begin
      check("cfg1_word", q_w1[0], 48'hA5F0);
      check("cfg1_frame", q_f1[0], 33);
    end
    check("cfg1_done_at", mon_lastdone[1] - se, 36);

    // Pending set accepted during channel 0.
    clear_mon();
    fire0({24'h222222, 24'h111111});
    ticks(20);
    fire0({24'h444444, 24'h333333});
    ticks(420);
    check("pend_nwords", q_w0.size(), 4);
    if (q_w0.size() >= 4) begin
      check("pend_w0", q_w0[0], 48'h111111);
      check("pend_w1", q_w0[1], 48'h222222);
      check("pend_w2", q_w0[2], 48'h333333);
      check("pend_w3", q_w0[3], 48'h444444);
    end
    check("pend_ndone", mon_dones[0], 2);

    // Latest busy-time send wins.
    clear_mon();
    fire0({24'hABCDEF, 24'h123456});
    ticks(30);
    fire0({24'h555555, 24'h555555});
    ticks(30);
    fire0({24'h666666, 24'h666666});
    ticks(430);
    check("ovr_nwords", q_w0.size(), 4);
    if (q_w0.size() >= 4) begin
      check("ovr_w2", q_w0[2], 48'h666666);
      check("ovr_w3", q_w0[3], 48'h666666);
    end
    check("ovr_ndone", mon_dones[0], 2);

    // Send on the final gap cycle restarts on the done cycle.
    clear_mon();
    se = cyc + 1;
    fire0({24'h0F0F0F, 24'hF0F0F0});
    ticks(199);
    fire0({24'hC3C3C3, 24'h3C3C3C});
    ticks(220);
    check("bnd_nframes", q_fall0.size(), 4);
    if (q_fall0.size() >= 4) begin
      check("bnd_restart_at", q_fall0[2] - se, 201);
      check("bnd_gap", q_g0[2], 2);
    end
    check("bnd_ndone", mon_dones[0], 2);

    // Random traffic on both configurations.
    repeat (1500) begin
      send0 = ($urandom_range(0, 39) == 0);
      d0    = {16'($urandom), 32'($urandom)};
      send1 = ($urandom_range(0, 15) == 0);
      d1    = 16'($urandom);
      tick();
    end
    send0 = 1'b0; send1 = 1'b0;
    ticks(250);

    // Reset mid-frame: CS must rise without waiting for a clock edge.
    fire0({24'h777777, 24'h888888});
    ticks(50);
    rst = 1'b1;
    #1;
    check("async_cs", cs0, 1'b1);
    check("async_busy", busy0, 1'b0);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    clear_mon();
    fire0({24'h0000FF, 24'hFF0000});
    ticks(210);
    check("post_rst_nwords", q_w0.size(), 2);
    if (q_w0.size() >= 2) begin
      check("post_rst_w0", q_w0[0], 48'hFF0000);
      check("post_rst_w1", q_w0[1], 48'h0000FF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
